// File: rtl/writeback_scheduler.sv
// writeback_scheduler
//   Sole owner of the register-file write port. Merges single-cycle ALU
//   results (highest priority, never stalled) with handshaked load/IO results
//   that are buffered in a small FIFO. A buffered load to the same register
//   as a later ALU write is cancelled (kill bit), so stale data never
//   overwrites newer data. Pending-hit outputs let decode stall on registers
//   whose write has not yet reached the register file.
//
// Optional feature macro: WRITEBACK_PROTECT_EN
//   When defined, writes to r28 (PC mirror) and r29 (input mirror) are
//   swallowed. The source is still consumed, and protect_drop pulses in the
//   slot where the write would have appeared.
//
// Ports
//   clock, reset                  clock (rising edge), async active-high reset
//   alu_valid/address/data        ALU result, one cycle, no backpressure
//   load_valid/ready/address/data load result handshake (ready = FIFO not full)
//   query_address1/2              decode read addresses
//   pending_hit1/2                query address has an uncommitted write
//   writeRegister/Address/Data    registered register-file write port
//   protect_drop                  (WRITEBACK_PROTECT_EN only) dropped write
//   fifo_count                    FIFO occupancy including killed entries
//   overflow_error                sticky: load offered while not ready
module writeback_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_address,
    input  logic [DW-1:0]              alu_data,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [AW-1:0]              load_address,
    input  logic [DW-1:0]              load_data,
    input  logic [AW-1:0]              query_address1,
    input  logic [AW-1:0]              query_address2,
    output logic                       pending_hit1,
    output logic                       pending_hit2,
    output logic                       writeRegister,
    output logic [AW-1:0]              writeAddress,
    output logic [DW-1:0]              writeData,
`ifdef WRITEBACK_PROTECT_EN
    output logic                       protect_drop,
`endif
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    fifo_addr [DEPTH];
    logic [DW-1:0]    fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [DEPTH-1:0] fifo_kill;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             accept;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             push_killed;
    logic             sel_valid;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;
    logic             drop_next;
    logic             wr_next;

    function automatic logic is_protected(input logic [AW-1:0] a);
`ifdef WRITEBACK_PROTECT_EN
        return (a == AW'(28)) || (a == AW'(29));
`else
        return 1'b0;
`endif
    endfunction

    assign load_ready = (count < CW'(DEPTH));
    assign fifo_count = count;

    assign accept      = load_valid && load_ready;
    assign pop         = !alu_valid && (count != '0);
    // Bypass only when nothing older could be waiting and the ALU is idle;
    // with the ALU busy the load is always pushed (and possibly pre-killed).
    assign bypass      = !alu_valid && (count == '0) && accept;
    assign push        = accept && !bypass;
    assign push_killed = alu_valid && (load_address == alu_address);

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = alu_address;
        sel_data  = alu_data;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (pop) begin
            // A killed head still pops but leaves a write bubble.
            sel_valid = !fifo_kill[rd_ptr];
            sel_addr  = fifo_addr[rd_ptr];
            sel_data  = fifo_data[rd_ptr];
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_addr  = load_address;
            sel_data  = load_data;
        end
        drop_next = sel_valid && is_protected(sel_addr);
        wr_next   = sel_valid && !drop_next;
    end

    always_comb begin
        pending_hit1 = writeRegister && (writeAddress == query_address1);
        pending_hit2 = writeRegister && (writeAddress == query_address2);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && !fifo_kill[i]) begin
                if (fifo_addr[i] == query_address1) pending_hit1 = 1'b1;
                if (fifo_addr[i] == query_address2) pending_hit2 = 1'b1;
            end
        end
    end

    // Payload storage: gated by fifo_valid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= load_address;
            fifo_data[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            fifo_valid     <= '0;
            fifo_kill      <= '0;
            overflow_error <= 1'b0;
            writeRegister  <= 1'b0;
            writeAddress   <= '0;
            writeData      <= '0;
`ifdef WRITEBACK_PROTECT_EN
            protect_drop   <= 1'b0;
`endif
        end else begin
            if (load_valid && !load_ready) overflow_error <= 1'b1;

            if (alu_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (fifo_valid[i] && (fifo_addr[i] == alu_address))
                        fifo_kill[i] <= 1'b1;
                end
            end
            if (pop) begin
                fifo_valid[rd_ptr] <= 1'b0;
                fifo_kill[rd_ptr]  <= 1'b0;
                rd_ptr             <= rd_ptr + PW'(1);
            end
            // The push slot is never live (FIFO not full), so this
            // overrides any kill-loop write to the same index harmlessly.
            if (push) begin
                fifo_valid[wr_ptr] <= 1'b1;
                fifo_kill[wr_ptr]  <= push_killed;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            writeRegister <= wr_next;
            if (wr_next) begin
                writeAddress <= sel_addr;
                writeData    <= sel_data;
            end
`ifdef WRITEBACK_PROTECT_EN
            protect_drop <= drop_next;
`endif
        end
    end

`ifndef WRITEBACK_PROTECT_EN
    logic unused_drop;
    assign unused_drop = drop_next;
`endif

endmodule

// File: tb/tb_writeback_scheduler.sv
module tb_writeback_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_address = '0;
    logic [DW-1:0] alu_data = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [AW-1:0] load_address = '0;
    logic [DW-1:0] load_data = '0;
    logic [AW-1:0] query_address1 = '0;
    logic [AW-1:0] query_address2 = '0;
    logic          pending_hit1;
    logic          pending_hit2;
    logic          writeRegister;
    logic [AW-1:0] writeAddress;
    logic [DW-1:0] writeData;
`ifdef WRITEBACK_PROTECT_EN
    logic          protect_drop;
`endif
    logic [2:0]    fifo_count;
    logic          overflow_error;

    int vectors = 0;
    int miscompares = 0;

    writeback_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_address(alu_address), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_address(load_address), .load_data(load_data),
        .query_address1(query_address1), .query_address2(query_address2),
        .pending_hit1(pending_hit1), .pending_hit2(pending_hit2),
        .writeRegister(writeRegister), .writeAddress(writeAddress),
        .writeData(writeData),
`ifdef WRITEBACK_PROTECT_EN
        .protect_drop(protect_drop),
`endif
        .fifo_count(fifo_count), .overflow_error(overflow_error)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid  = 1'b0;
        load_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%0h want=0", writeRegister); end
        vectors++; if (writeAddress !== 5'd0) begin miscompares++; $display("FAIL rst_addr got=%0h want=0", writeAddress); end
        vectors++; if (writeData !== 32'd0) begin miscompares++; $display("FAIL rst_data got=%0h want=0", writeData); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
        vectors++; if (overflow_error !== 1'b0) begin miscompares++; $display("FAIL rst_ovf got=%0h want=0", overflow_error); end
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%0h want=1", load_ready); end
        vectors++; if (pending_hit1 !== 1'b0) begin miscompares++; $display("FAIL rst_hit1 got=%0h want=0", pending_hit1); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'h1234;
        step();
        idle_inputs();
        vectors++; if (writeRegister !== 1'b1) begin miscompares++; $display("FAIL alu_we got=%0h want=1", writeRegister); end
        vectors++; if (writeAddress !== 5'd5) begin miscompares++; $display("FAIL alu_addr got=%0d want=5", writeAddress); end
        vectors++; if (writeData !== 32'h1234) begin miscompares++; $display("FAIL alu_data got=%0h want=1234", writeData); end
        step();
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL alu_we_next got=%0h want=0", writeRegister); end
        vectors++; if (writeAddress !== 5'd5) begin miscompares++; $display("FAIL alu_addr_hold got=%0d want=5", writeAddress); end
    endtask

    task automatic test_bypass();
        load_valid = 1'b1; load_address = 5'd7; load_data = 32'hCAFE;
        step();
        idle_inputs();
        vectors++; if (writeRegister !== 1'b1) begin miscompares++; $display("FAIL byp_we got=%0h want=1", writeRegister); end
        vectors++; if (writeAddress !== 5'd7) begin miscompares++; $display("FAIL byp_addr got=%0d want=7", writeAddress); end
        vectors++; if (writeData !== 32'hCAFE) begin miscompares++; $display("FAIL byp_data got=%0h want=cafe", writeData); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL byp_count got=%0d want=0", fifo_count); end
        step();
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL byp_we_next got=%0h want=0", writeRegister); end
    endtask

    task automatic test_collision_drain();
        for (int i = 0; i < 6; i++) begin
            vectors++; if (load_ready !== (i < 4)) begin miscompares++; $display("FAIL col_ready[%0d] got=%0h want=%0h", i, load_ready, (i < 4)); end
            alu_valid = 1'b1; alu_address = AW'(i + 1); alu_data = 32'h100 + i;
            load_valid = (i < 5); load_address = AW'(10 + i); load_data = 32'h200 + i;
            step();
            vectors++; if (writeRegister !== 1'b1 || writeAddress !== AW'(i + 1) || writeData !== 32'h100 + i) begin
                miscompares++; $display("FAIL col_alu[%0d] got=%0h/%0d/%0h want=1/%0d/%0h", i, writeRegister, writeAddress, writeData, i + 1, 32'h100 + i);
            end
            if (i == 3) begin
                query_address1 = 5'd10; query_address2 = 5'd14; #1;
                vectors++; if (pending_hit1 !== 1'b1) begin miscompares++; $display("FAIL col_hit_r10 got=%0h want=1", pending_hit1); end
                vectors++; if (pending_hit2 !== 1'b0) begin miscompares++; $display("FAIL col_hit_r14 got=%0h want=0", pending_hit2); end
                vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL col_count_full got=%0d want=4", fifo_count); end
                query_address1 = '0; query_address2 = '0;
            end
            if (i == 4) begin
                vectors++; if (overflow_error !== 1'b1) begin miscompares++; $display("FAIL col_ovf got=%0h want=1", overflow_error); end
            end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++; if (writeRegister !== 1'b1 || writeAddress !== AW'(10 + k) || writeData !== 32'h200 + k) begin
                miscompares++; $display("FAIL col_drain[%0d] got=%0h/%0d/%0h want=1/%0d/%0h", k, writeRegister, writeAddress, writeData, 10 + k, 32'h200 + k);
            end
        end
        step();
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL col_end_we got=%0h want=0", writeRegister); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL col_end_count got=%0d want=0", fifo_count); end
        vectors++; if (overflow_error !== 1'b1) begin miscompares++; $display("FAIL col_ovf_sticky got=%0h want=1", overflow_error); end
    endtask

    task automatic test_waw_kill();
        apply_reset();
        query_address1 = 5'd3;
        alu_valid = 1'b1; alu_address = 5'd20; alu_data = 32'h1;
        load_valid = 1'b1; load_address = 5'd3; load_data = 32'hAAAA;
        step();
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL waw_buffered got=%0d want=1", fifo_count); end
        vectors++; if (pending_hit1 !== 1'b1) begin miscompares++; $display("FAIL waw_hit_buf got=%0h want=1", pending_hit1); end
        load_valid = 1'b0; alu_address = 5'd3; alu_data = 32'hBBBB;
        step();
        idle_inputs();
        vectors++; if (writeRegister !== 1'b1 || writeAddress !== 5'd3 || writeData !== 32'hBBBB) begin
            miscompares++; $display("FAIL waw_alu got=%0h/%0d/%0h want=1/3/bbbb", writeRegister, writeAddress, writeData);
        end
        vectors++; if (pending_hit1 !== 1'b1) begin miscompares++; $display("FAIL waw_hit_out got=%0h want=1", pending_hit1); end
        step();
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL waw_bubble got=%0h want=0", writeRegister); end
        vectors++; if (pending_hit1 !== 1'b0) begin miscompares++; $display("FAIL waw_hit_clear got=%0h want=0", pending_hit1); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL waw_count got=%0d want=0", fifo_count); end
        // Same-cycle collision with an empty FIFO: load goes in pre-killed.
        alu_valid = 1'b1; alu_address = 5'd9; alu_data = 32'h99;
        load_valid = 1'b1; load_address = 5'd9; load_data = 32'h77;
        step();
        idle_inputs();
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL waw_same_push got=%0d want=1", fifo_count); end
        vectors++; if (writeData !== 32'h99) begin miscompares++; $display("FAIL waw_same_alu got=%0h want=99", writeData); end
        step();
        vectors++; if (writeRegister !== 1'b0 || writeData !== 32'h99) begin
            miscompares++; $display("FAIL waw_same_bubble got=%0h/%0h want=0/99", writeRegister, writeData);
        end
        query_address1 = '0;
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b1; alu_address = 5'd1; alu_data = 32'h11;
        load_valid = 1'b1; load_address = 5'd2; load_data = 32'h22;
        step();
        alu_valid = 1'b0; load_address = 5'd4; load_data = 32'h44;
        step();
        load_valid = 1'b0;
        vectors++; if (writeRegister !== 1'b1 || writeAddress !== 5'd2 || writeData !== 32'h22) begin
            miscompares++; $display("FAIL b2b_pop got=%0h/%0d/%0h want=1/2/22", writeRegister, writeAddress, writeData);
        end
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL b2b_count got=%0d want=1", fifo_count); end
        step();
        vectors++; if (writeRegister !== 1'b1 || writeAddress !== 5'd4 || writeData !== 32'h44) begin
            miscompares++; $display("FAIL b2b_second got=%0h/%0d/%0h want=1/4/44", writeRegister, writeAddress, writeData);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_address = 5'd30; alu_data = 32'h5000 + i;
            load_valid = 1'b1; load_address = AW'(21 + i); load_data = 32'h6000 + i;
            step();
        end
        idle_inputs();
        vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL mid_count_pre got=%0d want=3", fifo_count); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (writeRegister !== 1'b0 || writeAddress !== 5'd0 || writeData !== 32'd0) begin
            miscompares++; $display("FAIL mid_async_out got=%0h/%0d/%0h want=0/0/0", writeRegister, writeAddress, writeData);
        end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL mid_async_count got=%0d want=0", fifo_count); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL mid_after[%0d] got=%0h want=0", i, writeRegister); end
        end
    endtask

    task automatic test_protect();
        alu_valid = 1'b1; alu_address = 5'd29; alu_data = 32'hDEAD;
        step();
        idle_inputs();
`ifdef WRITEBACK_PROTECT_EN
        vectors++; if (writeRegister !== 1'b0) begin miscompares++; $display("FAIL prot_we got=%0h want=0", writeRegister); end
        vectors++; if (protect_drop !== 1'b1) begin miscompares++; $display("FAIL prot_drop got=%0h want=1", protect_drop); end
        step();
        vectors++; if (protect_drop !== 1'b0) begin miscompares++; $display("FAIL prot_drop_next got=%0h want=0", protect_drop); end
`else
        vectors++; if (writeRegister !== 1'b1 || writeAddress !== 5'd29 || writeData !== 32'hDEAD) begin
            miscompares++; $display("FAIL prot_off got=%0h/%0d/%0h want=1/29/dead", writeRegister, writeAddress, writeData);
        end
        step();
`endif
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_bypass();
        test_collision_drain();
        test_waw_kill();
        test_back_to_back();
        test_reset_mid();
        test_protect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
